// File: rtl/spi_xfer_seq.sv
// Byte sequencer that feeds an SPI master from a TX FIFO and collects its replies into an RX FIFO.
// Optional WAIT-state timeout is compiled in with `define SPI_SEQ_TIMEOUT_EN.
module spi_xfer_seq #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       m_start,
    output logic [7:0] m_tdat,
    input  logic       m_done,
    input  logic [7:0] m_rdata,
    output logic       busy,
    output logic [4:0] tx_count,
    output logic [4:0] rx_count,
    output logic       err_timeout
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_xfer_seq: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
    end

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [4:0]    tx_cnt_q, rx_cnt_q;
    logic [4:0]    tx_cnt_d, rx_cnt_d;

    state_t        state_q, state_d;
    logic          start_cyc_q, start_cyc_d;
    logic [7:0]    m_tdat_q, m_tdat_d;
    logic          m_start_q, m_start_d;
    logic          busy_q, busy_d;
    logic          m_done_q;

    logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic          done_rise_s, timeout_s;

    assign tx_ready    = (tx_cnt_q != DEPTH_C);
    assign rx_valid    = (rx_cnt_q != 5'd0);
    assign rx_data     = rx_mem_q[rx_rd_q];
    assign tx_push_s   = tx_valid && tx_ready;
    assign rx_pop_s    = rx_valid && rx_ready;
    // A done level left over from the previous byte is not an edge, so it is ignored.
    assign done_rise_s = m_done && !m_done_q;

    assign m_start  = m_start_q;
    assign m_tdat   = m_tdat_q;
    assign busy     = busy_q;
    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;
    logic          err_to_q;

    assign timeout_s   = (state_q == ST_WAIT) && !done_rise_s &&
                         (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_to_q;

    // WAIT-cycle counter (held at zero outside WAIT) and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (timeout_s) begin
                err_to_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_s   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_cyc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cyc_q <= start_cyc_d;
        end
    end

    // FSM next-state logic; a transfer starts only if a free RX slot is already reserved.
    always_comb begin
        state_d     = state_q;
        start_cyc_d = start_cyc_q;
        case (state_q)
            ST_IDLE: begin
                if ((tx_cnt_q != 5'd0) && (rx_cnt_q < DEPTH_C)) begin
                    state_d     = ST_START;
                    start_cyc_d = 1'b0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_START: begin
                if (start_cyc_q) begin
                    state_d = ST_WAIT;
                end else begin
                    start_cyc_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (done_rise_s || timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                start_cyc_d = 1'b0;
            end
        endcase
    end

    // FSM outputs: FIFO strobes and next values of the registered master-side outputs.
    always_comb begin
        tx_pop_s  = (state_q == ST_IDLE) && (state_d == ST_START);
        rx_push_s = (state_q == ST_WAIT) && done_rise_s;
        m_start_d = (state_d == ST_START);
        busy_d    = (state_d != ST_IDLE);
        if (tx_pop_s) begin
            m_tdat_d = tx_mem_q[tx_rd_q];
        end else begin
            m_tdat_d = m_tdat_q;
        end
    end

    // Registered master-side outputs and the done-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_start_q <= 1'b0;
            m_tdat_q  <= 8'hFF;
            busy_q    <= 1'b0;
            m_done_q  <= 1'b0;
        end else begin
            m_start_q <= m_start_d;
            m_tdat_q  <= m_tdat_d;
            busy_q    <= busy_d;
            m_done_q  <= m_done;
        end
    end

    // Occupancy next-state; a simultaneous push and pop cancel out.
    always_comb begin
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + 5'd1;
            2'b01:   tx_cnt_d = tx_cnt_q - 5'd1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + 5'd1;
            2'b01:   rx_cnt_d = rx_cnt_q - 5'd1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // FIFO pointers and counts; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_cnt_q <= 5'd0;
            rx_cnt_q <= 5'd0;
        end else begin
            if (tx_push_s) begin
                tx_wr_q <= tx_wr_q + AW'(1);
            end
            if (tx_pop_s) begin
                tx_rd_q <= tx_rd_q + AW'(1);
            end
            if (rx_push_s) begin
                rx_wr_q <= rx_wr_q + AW'(1);
            end
            if (rx_pop_s) begin
                rx_rd_q <= rx_rd_q + AW'(1);
            end
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the counts gate visibility.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_q] <= tx_data;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wr_q] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: vector table plus scoreboarded multi-cycle sequences.
module tb_spi_xfer_seq;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 16;
    localparam int LONG_DLY = 12;
`else
    localparam int TO_CYC = 4096;
    localparam int LONG_DLY = 20;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       m_start;
    logic [7:0] m_tdat;
    logic       m_done = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       busy;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
    logic       err_timeout;

    spi_xfer_seq #(.DEPTH(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .m_start(m_start), .m_tdat(m_tdat), .m_done(m_done), .m_rdata(m_rdata),
        .busy(busy), .tx_count(tx_count), .rx_count(rx_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        int         dly;
        logic [7:0] rx;
    } vec_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    // master model controls
    bit         auto_done = 1'b1;
    int         master_delay = 5;
    logic       man_done = 1'b0;
    logic [7:0] man_rdata = 8'h00;
    int         n_starts = 0;

    function automatic logic [7:0] resp(input logic [7:0] b);
        return b ^ 8'h99;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        bit ok = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (tx_ready) ok = 1'b1;
            tick(1);
        end
        tx_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
        if (ok) begin
            exp_tx.push_back(b);
            exp_rx.push_back(resp(b));
        end
    endtask

    task automatic wait_rx(input int n, input string name);
        for (int k = 0; k < 300 && int'(rx_count) != n; k++) tick(1);
        check(name, 32'(rx_count), 32'(n));
    endtask

    task automatic pop_rx(input string name);
        logic [7:0] e;
        for (int k = 0; k < 300 && !rx_valid; k++) tick(1);
        check({name, "_valid"}, 32'(rx_valid), 32'd1);
        if (exp_rx.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: rx_data got %0h with no byte expected", name, rx_data);
        end else begin
            e = exp_rx.pop_front();
            check(name, 32'(rx_data), 32'(e));
        end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Master model and bus monitor, sampling on the falling edge.
    initial begin
        logic       prev_start = 1'b0;
        logic       prev_busy = 1'b0;
        logic       held_ok = 1'b1;
        logic [7:0] cur_tdat = 8'h00;
        int         run = 0;
        int         cd = 0;
        forever begin
            @(negedge clk);
            if (m_start && !prev_start) begin
                n_starts++;
                cur_tdat = m_tdat;
                held_ok  = 1'b1;
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL m_tdat: start with %0h but no byte queued", m_tdat);
                end else begin
                    check("m_tdat_order", 32'(m_tdat), 32'(exp_tx.pop_front()));
                end
                if (auto_done) begin
                    m_done = 1'b0;
                    cd     = master_delay;
                end
            end else if (auto_done && cd > 0) begin
                cd--;
                if (cd == 0) begin
                    m_done  = 1'b1;
                    m_rdata = resp(cur_tdat);
                end
            end
            if (!auto_done) begin
                m_done  = man_done;
                m_rdata = man_rdata;
                cd      = 0;
            end
            if (m_start) begin
                run++;
            end else if (run > 0) begin
                check("m_start_len", 32'(run), 32'd2);
                run = 0;
            end
            if (busy && m_tdat != cur_tdat) held_ok = 1'b0;
            if (prev_busy && !busy) check("m_tdat_held", 32'(held_ok), 32'd1);
            prev_start = m_start;
            prev_busy  = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   base;
        int   bcyc;
        tbl[0] = '{8'hA5, LONG_DLY, 8'h3C};
        tbl[1] = '{8'h00, 3, 8'h99};
        tbl[2] = '{8'hFF, 5, 8'h66};
        tbl[3] = '{8'h5A, 9, 8'hC3};

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_m_start", 32'(m_start), 32'd0);
        check("rst_m_tdat", 32'(m_tdat), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);

        // single transfers from the table
        for (int i = 0; i < 4; i++) begin
            master_delay = tbl[i].dly;
            push_tx(tbl[i].tx);
            wait_rx(1, "vec_rx_count");
            check("vec_busy_idle", 32'(busy), 32'd0);
            check("vec_rx_data", 32'(rx_data), 32'(tbl[i].rx));
            pop_rx("vec_pop");
        end

        // RX back-pressure fills RX, then TX fills and stalls
        master_delay = 5;
        base = n_starts;
        for (int i = 0; i < 4; i++) push_tx(8'h30 + 8'(i));
        wait_rx(4, "bp_rx_full");
        push_tx(8'h40);
        tick(30);
        check("bp_no_5th_start", 32'(n_starts - base), 32'd4);
        check("bp_tx_count1", 32'(tx_count), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        for (int i = 1; i < 4; i++) push_tx(8'h40 + 8'(i));
        check("bp_tx_full", 32'(tx_count), 32'd4);
        check("bp_tx_ready0", 32'(tx_ready), 32'd0);
        tx_data  = 8'h44;
        tx_valid = 1'b1;
        tick(4);
        tx_valid = 1'b0;
        check("bp_full_ignored", 32'(tx_count), 32'd4);
        pop_rx("bp_pop_first");
        check("bp_still_stalled", 32'(tx_ready), 32'd0);
        push_tx(8'h44);
        tick(2);
        check("bp_5th_started", 32'(n_starts - base), 32'd5);
        for (int i = 0; i < 8; i++) pop_rx("bp_drain");

        // done level held over from the previous transfer
        man_done  = 1'b1;
        man_rdata = 8'hEE;
        auto_done = 1'b0;
        push_tx(8'h11);
        tick(6);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_no_push", 32'(rx_count), 32'd0);
        man_done = 1'b0;
        tick(3);
        check("hold_low_no_push", 32'(rx_count), 32'd0);
        man_rdata = 8'h88;
        man_done  = 1'b1;
        tick(3);
        check("hold_rise_push", 32'(rx_count), 32'd1);
        check("hold_idle", 32'(busy), 32'd0);
        pop_rx("hold_pop");
        auto_done = 1'b1;

        // reset in WAIT
        master_delay = 15;
        push_tx(8'h22);
        tick(6);
        check("rw_in_wait", 32'({busy, m_start}), 32'b10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_rx.delete();
        check("rw_tx_count", 32'(tx_count), 32'd0);
        check("rw_rx_count", 32'(rx_count), 32'd0);
        check("rw_m_start", 32'(m_start), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_m_tdat", 32'(m_tdat), 32'hFF);
        tick(25);
        check("rw_no_late_push", 32'(rx_count), 32'd0);
        check("rw_rx_valid", 32'(rx_valid), 32'd0);

`ifdef SPI_SEQ_TIMEOUT_EN
        man_done  = 1'b0;
        auto_done = 1'b0;
        tick(2);
        push_tx(8'h33);
        exp_rx.delete();
        for (int k = 0; k < 20 && !busy; k++) tick(1);
        bcyc = 0;
        for (int k = 0; k < 60 && busy; k++) begin
            bcyc++;
            tick(1);
        end
        check("to_busy_cycles", 32'(bcyc), 32'd18);
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        check("to_rx_count", 32'(rx_count), 32'd0);
        tick(5);
        check("to_sticky", 32'(err_timeout), 32'd1);
`else
        bcyc = 0;
        check("no_timeout_err", 32'(err_timeout + bcyc), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
